fir_unfolded_param: RTL and testbench
=====================================

Name: fir_unfolded_param

Overview:
Parametrised successor to the fixed 3-way unfolded, 11-tap, 8-bit pipelined FIR. Processes L samples per clock for arbitrary tap count and data width. Holds coefficients in a double-buffered (shadow/active) register bank loaded through a write port, instead of static B0..B10 pins. Sits between data_maker-style sources and data_sink-style consumers in the filter datapath.

Parameters:
NBIT, 8, signed data and coefficient width (two's complement, Q1.(NBIT-1))
NTAPS, 11, filter order + 1 (number of coefficients), >=2
L, 3, unfolding factor (lanes per clock), >=1
AW, 4, coefficient address width; 2**AW >= NTAPS

Ports:
CLK  in  1  clock, all logic rising-edge
RST  in  1  synchronous, active-high reset
VIN  in  1  input lanes valid this cycle
DIN  in  L*NBIT  lane j at bits [j*NBIT +: NBIT]; lane 0 oldest sample x[Lk], lane L-1 newest x[Lk+L-1]
COEF_WE  in  1  write COEF_DATA to shadow[COEF_ADDR]
COEF_ADDR  in  AW  coefficient index i (b_i)
COEF_DATA  in  NBIT  signed coefficient
COEF_COMMIT  in  1  copy shadow bank to active bank
VOUT  out  1  output lanes valid
DOUT  out  L*NBIT  lane j = y[Lk+j], same packing as DIN
COEF_BUSY  out  1  high the cycle after a commit (active bank just changed)

Behaviour:
- Reset (RST=1 at edge): VOUT=0, DOUT=0, COEF_BUSY=0, delay line, all pipeline regs, shadow and active banks cleared to 0. Reset wins over every other input the same cycle; in-flight samples are discarded, no VOUT afterwards for them.
- Function: y[n] = sum_{i=0..NTAPS-1} b_i * x[n-i], x[m<0 or pre-reset] = 0, using active coefficients.
- Delay line holds the last NTAPS-1 samples; it shifts by L samples only on cycles with VIN=1; with VIN=0 it holds (gaps do not insert zeros).
- Pipeline, fixed latency LAT=3: stage 1 registers DIN+taps snapshot and active coeffs; stage 2 registers NTAPS*L products (2*NBIT signed); stage 3 registers summed, scaled, saturated outputs. Valid bit travels with data; VOUT at cycle t+3 iff VIN at t. Back-to-back VIN gives VOUT every cycle; no stall/backpressure.
- Arithmetic: accumulate at full width 2*NBIT+clog2(NTAPS); result = arithmetic shift right by NBIT-1 (floor); saturate to [-2^(NBIT-1), 2^(NBIT-1)-1].
- Coefficient load: COEF_WE writes shadow[COEF_ADDR]; addresses >= NTAPS ignored. Active bank is untouched until COEF_COMMIT.
- Commit: on COEF_COMMIT edge, active <= shadow including any same-cycle COEF_WE write. Samples with VIN on the commit cycle use the old bank; samples from the next cycle use the new bank. In-flight samples are unaffected. COEF_BUSY=1 exactly the cycle following a commit (informational only; inputs still accepted).
- Commit with no prior writes copies zeros (post-reset) -> outputs 0.

Decomposition:
- Package fir_pkg: clog2 function, LAT=3 constant, ACCW(NBIT,NTAPS) width function, saturate function.
- One sub-module fir_phase: computes one output lane (NTAPS products, adder tree, scale/sat) from a tap window; instantiated L times via generate. The top holds the delay line, coefficient banks and the valid pipeline.

Test Plan:
1. Impulse (NBIT=8, NTAPS=11, L=3): load b_i=2*(i+1), commit, feed x=64 then zeros (4 VIN cycles) -> flattened y sequence 1,2,...,11 then 0; first VOUT exactly 3 cycles after first VIN.
2. Saturation: all b_i=127, all x=127 for 4 cycles -> DOUT lanes 127 once the window is full; all x=-128 -> -128.
3. VIN gaps: impulse of test 1 with VIN low for 5 cycles between every group -> identical y sequence, VOUT pattern equals VIN pattern delayed by 3.
4. Shadow isolation/commit timing: active b_0=2, write shadow b_0=4 without commit, x=64 DC -> y=1; commit with VIN same cycle -> that group y=1, next group y=2; COEF_BUSY pulses 1 cycle; write to addr 12 has no effect.
5. Reset mid-stream: assert RST 1 cycle while 2 groups in flight -> VOUT=0 next cycle, no outputs for in-flight groups, later input uses zero coefficients -> y=0.
6. Random regression, L=1,2,4 and NTAPS=5,16: random x, random b -> DOUT matches golden model bit-exactly with latency 3.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and arithmetic helpers for the parametrised unfolded FIR.
package fir_pkg;

   // Fixed pipeline depth from sample acceptance to output: snapshot, products, sum.
   localparam int LAT = 3;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Accumulator width that can never overflow for ntaps full-scale products.
   function automatic int accw(input int nbit, input int ntaps);
      return 2 * nbit + clog2(ntaps);
   endfunction

   // Clamp a signed value to the nbit two's complement range.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                   input int nbit);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (nbit - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (nbit - 1));
      if (value > max_v) begin
         return max_v;
      end else if (value < min_v) begin
         return min_v;
      end
      return value;
   endfunction

endpackage

// File: rtl/fir_phase.sv
// One output lane: registered per-tap products, adder tree, scale and saturate.
module fir_phase
   import fir_pkg::*;
#(
   parameter int NBIT  = 8,
   parameter int NTAPS = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NTAPS*NBIT-1:0] taps,   // tap i holds x[n-i]
   input  logic [NTAPS*NBIT-1:0] coefs,  // coefficient i holds b_i
   output logic [NBIT-1:0]       y
);

   localparam int ACCW = accw(NBIT, NTAPS);

   logic signed [2*NBIT-1:0] prod_d [NTAPS];
   logic signed [2*NBIT-1:0] prod_q [NTAPS];
   logic signed [ACCW-1:0]   sum;
   logic signed [ACCW-1:0]   scaled;
   logic        [NBIT-1:0]   y_d;

   // Full-precision signed products of each tap with its coefficient.
   always_comb begin
      for (int i = 0; i < NTAPS; i++) begin
         prod_d[i] = (2*NBIT)'($signed(taps[i*NBIT +: NBIT]))
                   * (2*NBIT)'($signed(coefs[i*NBIT +: NBIT]));
      end
   end

   // Stage 2: register all products of this lane.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NTAPS; i++) begin
         if (rst) begin
            prod_q[i] <= '0;
         end else begin
            prod_q[i] <= prod_d[i];
         end
      end
   end

   // Sum at full width, floor-shift back to Q1.(NBIT-1), then clamp.
   always_comb begin
      sum = '0;
      for (int i = 0; i < NTAPS; i++) begin
         sum = sum + ACCW'(prod_q[i]);
      end
      scaled = sum >>> (NBIT - 1);
      y_d    = NBIT'(saturate(64'(scaled), NBIT));
   end

   // Stage 3: registered lane output.
   always_ff @(posedge clk) begin
      if (rst) begin
         y <= '0;
      end else begin
         y <= y_d;
      end
   end

endmodule

// File: rtl/fir_unfolded_param.sv
// L-lane unfolded FIR with double-buffered coefficient bank and fixed 3-cycle latency.
module fir_unfolded_param
   import fir_pkg::*;
#(
   parameter int NBIT  = 8,
   parameter int NTAPS = 11,
   parameter int L     = 3,
   parameter int AW    = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            VIN,
   input  logic [L*NBIT-1:0] DIN,
   input  logic            COEF_WE,
   input  logic [AW-1:0]   COEF_ADDR,
   input  logic [NBIT-1:0] COEF_DATA,
   input  logic            COEF_COMMIT,
   output logic            VOUT,
   output logic [L*NBIT-1:0] DOUT,
   output logic            COEF_BUSY
);

   localparam int HLEN = NTAPS - 1;      // history samples kept between groups
   localparam int WLEN = L + NTAPS - 1;  // samples spanned by one group of outputs

   logic [NBIT-1:0]       hist_q   [HLEN];
   logic [NBIT-1:0]       shadow_q [NTAPS];
   logic [NBIT-1:0]       shadow_d [NTAPS];
   logic [NBIT-1:0]       active_q [NTAPS];
   logic [WLEN*NBIT-1:0]  win;
   logic [WLEN*NBIT-1:0]  win_q;
   logic [NTAPS*NBIT-1:0] coef_q;
   logic [LAT-1:0]        valid_q;
   logic                  busy_q;

   // Sample window, index 0 newest: incoming lanes reversed, then the history.
   always_comb begin
      win = '0;
      for (int m = 0; m < L; m++) begin
         win[m*NBIT +: NBIT] = DIN[(L-1-m)*NBIT +: NBIT];
      end
      for (int m = 0; m < HLEN; m++) begin
         win[(L+m)*NBIT +: NBIT] = hist_q[m];
      end
   end

   // Shadow bank with this cycle's write folded in, so a same-cycle commit sees it.
   always_comb begin
      for (int i = 0; i < NTAPS; i++) begin
         shadow_d[i] = shadow_q[i];
         if (COEF_WE && (COEF_ADDR == AW'(i))) begin
            shadow_d[i] = COEF_DATA;
         end
      end
   end

   // Delay line advances by one group only when lanes are valid.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int m = 0; m < HLEN; m++) begin
            hist_q[m] <= '0;
         end
      end else if (VIN) begin
         for (int m = 0; m < HLEN; m++) begin
            hist_q[m] <= win[m*NBIT +: NBIT];
         end
      end
   end

   // Coefficient banks: writes land in shadow, commit copies shadow to active.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NTAPS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         shadow_q <= shadow_d;
         if (COEF_COMMIT) begin
            active_q <= shadow_d;
         end
      end
   end

   // Stage 1 snapshot of window and active coefficients, plus valid and busy tracking.
   always_ff @(posedge CLK) begin
      if (RST) begin
         win_q   <= '0;
         coef_q  <= '0;
         valid_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         win_q <= win;
         for (int i = 0; i < NTAPS; i++) begin
            coef_q[i*NBIT +: NBIT] <= active_q[i];
         end
         valid_q <= {valid_q[LAT-2:0], VIN};
         busy_q  <= COEF_COMMIT;
      end
   end

   // Lane j needs x[Lk+j-i], which starts at window index L-1-j.
   for (genvar j = 0; j < L; j++) begin : g_lane
      fir_phase #(
         .NBIT  (NBIT),
         .NTAPS (NTAPS)
      ) u_phase (
         .clk   (CLK),
         .rst   (RST),
         .taps  (win_q[(L-1-j)*NBIT +: NTAPS*NBIT]),
         .coefs (coef_q),
         .y     (DOUT[j*NBIT +: NBIT])
      );
   end

   assign VOUT      = valid_q[LAT-1];
   assign COEF_BUSY = busy_q;

endmodule

// File: tb/tb_fir_unfolded_param.sv
// Directed and random checks of three FIR configurations against a sample-history model.
module tb_fir_unfolded_param;

   logic        clk = 1'b0;
   logic [2:0]  rst_s, vin, we_s, cm_s, vout, busy;
   logic [3:0]  addr_s [3];
   logic [7:0]  data_s [3];
   logic [23:0] din_a, dout_a;
   logic [15:0] din_b, dout_b;
   logic [31:0] din_c, dout_c;

   always #5 clk = ~clk;

   fir_unfolded_param #(.NBIT(8), .NTAPS(11), .L(3), .AW(4)) dut_a (
      .CLK(clk), .RST(rst_s[0]), .VIN(vin[0]), .DIN(din_a), .COEF_WE(we_s[0]),
      .COEF_ADDR(addr_s[0]), .COEF_DATA(data_s[0]), .COEF_COMMIT(cm_s[0]),
      .VOUT(vout[0]), .DOUT(dout_a), .COEF_BUSY(busy[0]));

   fir_unfolded_param #(.NBIT(8), .NTAPS(16), .L(2), .AW(4)) dut_b (
      .CLK(clk), .RST(rst_s[1]), .VIN(vin[1]), .DIN(din_b), .COEF_WE(we_s[1]),
      .COEF_ADDR(addr_s[1]), .COEF_DATA(data_s[1]), .COEF_COMMIT(cm_s[1]),
      .VOUT(vout[1]), .DOUT(dout_b), .COEF_BUSY(busy[1]));

   fir_unfolded_param #(.NBIT(8), .NTAPS(5), .L(4), .AW(3)) dut_c (
      .CLK(clk), .RST(rst_s[2]), .VIN(vin[2]), .DIN(din_c), .COEF_WE(we_s[2]),
      .COEF_ADDR(addr_s[2][2:0]), .COEF_DATA(data_s[2]), .COEF_COMMIT(cm_s[2]),
      .VOUT(vout[2]), .DOUT(dout_c), .COEF_BUSY(busy[2]));

   // Reference model state per configuration.
   int nt_of [3] = '{11, 16, 5};
   int l_of  [3] = '{3, 2, 4};
   int xs    [3][2048];   // every accepted sample since reset, oldest first
   int xn    [3];
   int act   [3][16];
   int shd   [3][16];
   int due_q [3][$];      // cycle at which each pending group must appear
   int ys_q  [3][$];      // expected lane values of pending groups, lane 0 first
   bit busy_exp [3];
   int xin [4];
   int cyc, total, bad;

   // y[n] = sum b_i x[n-i], floor-scaled by 2^7 and clamped to 8 bits.
   function automatic int yref(int d, int n);
      longint acc;
      acc = 0;
      for (int i = 0; i < nt_of[d]; i++) begin
         if (n - i >= 0) acc += longint'(act[d][i]) * longint'(xs[d][n-i]);
      end
      acc = acc >>> 7;
      if (acc > 127) acc = 127;
      else if (acc < -128) acc = -128;
      return int'(acc);
   endfunction

   function automatic logic [7:0] dout_of(int d, int j);
      if (d == 0) return dout_a[j*8 +: 8];
      if (d == 1) return dout_b[j*8 +: 8];
      return dout_c[j*8 +: 8];
   endfunction

   task automatic set_x(input int a, input int b, input int c, input int e);
      xin[0] = a; xin[1] = b; xin[2] = c; xin[3] = e;
   endtask

   task automatic check_all();
      bit ev;
      int e;
      for (int k = 0; k < 3; k++) begin
         ev = (due_q[k].size() > 0) && (due_q[k][0] == cyc);
         total++;
         assert (vout[k] === ev) else begin
            bad++;
            $error("FAIL vout dut%0d cyc=%0d got=%b want=%b", k, cyc, vout[k], ev);
         end
         if (ev) begin
            e = due_q[k].pop_front();
            for (int j = 0; j < l_of[k]; j++) begin
               e = ys_q[k].pop_front();
               total++;
               assert (dout_of(k, j) === 8'(e)) else begin
                  bad++;
                  $error("FAIL dout dut%0d lane%0d cyc=%0d got=%0d want=%0d", k, j, cyc,
                         $signed(dout_of(k, j)), e);
               end
            end
         end
         total++;
         assert (busy[k] === busy_exp[k]) else begin
            bad++;
            $error("FAIL busy dut%0d cyc=%0d got=%b want=%b", k, cyc, busy[k], busy_exp[k]);
         end
      end
   endtask

   // One clock: drive configuration d, advance the model, then check every DUT.
   task automatic step(input int d, input bit v, input bit we, input int addr, input int data,
                       input bit cm, input bit [2:0] rmask);
      int n0;
      rst_s = rmask;
      vin = '0; we_s = '0; cm_s = '0;
      vin[d] = v; we_s[d] = we; cm_s[d] = cm;
      for (int k = 0; k < 3; k++) begin
         addr_s[k] = 4'(addr);
         data_s[k] = 8'(data);
      end
      din_a = '0; din_b = '0; din_c = '0;
      for (int j = 0; j < l_of[d]; j++) begin
         if (d == 0) din_a[j*8 +: 8] = 8'(xin[j]);
         else if (d == 1) din_b[j*8 +: 8] = 8'(xin[j]);
         else din_c[j*8 +: 8] = 8'(xin[j]);
      end
      for (int k = 0; k < 3; k++) begin
         busy_exp[k] = 1'b0;
         if (rmask[k]) begin
            xn[k] = 0;
            for (int i = 0; i < 16; i++) begin
               act[k][i] = 0;
               shd[k][i] = 0;
            end
            due_q[k].delete();
            ys_q[k].delete();
         end
      end
      if (!rmask[d]) begin
         if (v) begin
            n0 = xn[d];
            for (int j = 0; j < l_of[d]; j++) begin
               xs[d][xn[d]] = xin[j];
               xn[d]++;
            end
            for (int j = 0; j < l_of[d]; j++) ys_q[d].push_back(yref(d, n0 + j));
            due_q[d].push_back(cyc + 3);
         end
         if (we && addr < nt_of[d]) shd[d][addr] = data;
         if (cm) for (int i = 0; i < 16; i++) act[d][i] = shd[d][i];
         busy_exp[d] = cm;
      end
      @(posedge clk);
      cyc++;
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 0, 0, 1'b0, 3'b000);
   endtask

   task automatic load_impulse();
      for (int i = 0; i < 11; i++) step(0, 1'b0, 1'b1, i, 2 * (i + 1), 1'b0, 3'b000);
      step(0, 1'b0, 1'b0, 0, 0, 1'b1, 3'b000);
   endtask

   initial begin
      int v, we, cm, addr;
      cyc = 0; total = 0; bad = 0;
      set_x(0, 0, 0, 0);
      rst_s = 3'b111; vin = '0; we_s = '0; cm_s = '0;
      din_a = '0; din_b = '0; din_c = '0;
      for (int k = 0; k < 3; k++) begin
         addr_s[k] = '0;
         data_s[k] = '0;
      end

      // Reset state.
      step(0, 1'b0, 1'b0, 0, 0, 1'b0, 3'b111);
      total++;
      assert (dout_a === 24'h0) else begin
         bad++;
         $error("FAIL reset_dout got=%h want=0", dout_a);
      end

      // Impulse response: y = 1..11 then zeros.
      load_impulse();
      set_x(64, 0, 0, 0);
      step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b000);
      set_x(0, 0, 0, 0);
      repeat (3) step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b000);
      idle(4);

      // Saturation at both rails.
      for (int i = 0; i < 11; i++) step(0, 1'b0, 1'b1, i, 127, 1'b0, 3'b000);
      step(0, 1'b0, 1'b0, 0, 0, 1'b1, 3'b000);
      set_x(127, 127, 127, 0);
      repeat (4) step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b000);
      set_x(-128, -128, -128, 0);
      repeat (4) step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b000);
      idle(4);

      // Impulse with gaps: VIN low must not insert zeros into the history.
      step(0, 1'b0, 1'b0, 0, 0, 1'b0, 3'b001);
      load_impulse();
      for (int g = 0; g < 4; g++) begin
         if (g == 0) set_x(64, 0, 0, 0);
         else set_x(0, 0, 0, 0);
         step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b000);
         idle(5);
      end

      // Shadow isolation and commit timing.
      step(0, 1'b0, 1'b0, 0, 0, 1'b0, 3'b001);
      step(0, 1'b0, 1'b1, 0, 2, 1'b0, 3'b000);
      step(0, 1'b0, 1'b0, 0, 0, 1'b1, 3'b000);
      step(0, 1'b0, 1'b1, 0, 4, 1'b0, 3'b000);
      set_x(64, 64, 64, 0);
      repeat (3) step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b000);
      step(0, 1'b1, 1'b0, 0, 0, 1'b1, 3'b000);
      repeat (2) step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b000);
      step(0, 1'b0, 1'b1, 12, 99, 1'b0, 3'b000);
      step(0, 1'b0, 1'b0, 0, 0, 1'b1, 3'b000);
      repeat (2) step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b000);
      step(0, 1'b1, 1'b1, 1, 6, 1'b1, 3'b000);
      repeat (2) step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b000);
      idle(4);

      // Reset with two groups in flight, then zero coefficients give y = 0.
      step(0, 1'b0, 1'b1, 0, 64, 1'b1, 3'b000);
      set_x(100, -50, 25, 0);
      repeat (2) step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b000);
      step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b001);
      idle(4);
      step(0, 1'b1, 1'b0, 0, 0, 1'b0, 3'b000);
      idle(4);

      // Random regression on every configuration.
      for (int d = 0; d < 3; d++) begin
         step(d, 1'b0, 1'b0, 0, 0, 1'b0, 3'(1 << d));
         for (int i = 0; i < nt_of[d]; i++)
            step(d, 1'b0, 1'b1, i, int'($urandom_range(0, 255)) - 128, 1'b0, 3'b000);
         step(d, 1'b0, 1'b0, 0, 0, 1'b1, 3'b000);
         for (int s = 0; s < 80; s++) begin
            v    = ($urandom_range(0, 3) != 0) ? 1 : 0;
            we   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            cm   = ($urandom_range(0, 7) == 0) ? 1 : 0;
            addr = int'($urandom_range(0, (d == 2) ? 7 : 15));
            for (int j = 0; j < 4; j++) xin[j] = int'($urandom_range(0, 255)) - 128;
            step(d, v[0], we[0], addr, int'($urandom_range(0, 255)) - 128, cm[0], 3'b000);
         end
         for (int i = 0; i < 4; i++) step(d, 1'b0, 1'b0, 0, 0, 1'b0, 3'b000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
